// File: rtl/serial_slice_adder.sv
// Wide adder/subtractor that pushes operands LSB-first through one SLICE-bit adder per cycle.
// Optional signed-overflow output: define SERIAL_SLICE_ADDER_OVF_EN.
module serial_slice_adder #(
  parameter int WIDTH = 64,
  parameter int SLICE = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             busy
`ifdef SERIAL_SLICE_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both 1.
  // in_valid/out_ready may change freely; in_ready/out_valid are registered.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_next;

  logic [WIDTH-1:0] a_q, b_q, acc, acc_next;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic [SLICE-1:0] a_sl, b_sl, sum_sl;
  logic             c_sl;
  logic             accept, last;

  assign accept = (state == IDLE) && in_valid && in_ready;
  assign last   = (cnt == LAST);
  assign busy   = (state != IDLE);

  // Slice mux and the single shared SLICE-bit adder.
  always_comb begin
    a_sl = '0;
    b_sl = '0;
    for (int k = 0; k < NSLICE; k++) begin
      if (cnt == CW'(k)) begin
        a_sl = a_q[k*SLICE +: SLICE];
        b_sl = b_q[k*SLICE +: SLICE];
      end
    end
  end

  assign {c_sl, sum_sl} = {1'b0, a_sl} + {1'b0, b_sl} + {{SLICE{1'b0}}, carry};

  // Accumulator with the current slice merged in, so the last slice can go straight to S.
  always_comb begin
    acc_next = acc;
    for (int k = 0; k < NSLICE; k++) begin
      if (cnt == CW'(k)) acc_next[k*SLICE +: SLICE] = sum_sl;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = RUN;
      RUN:     if (last) state_next = DONE;
      DONE:    if (out_valid && out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q       <= '0;
      b_q       <= '0;
      acc       <= '0;
      carry     <= 1'b0;
      cnt       <= '0;
      S         <= '0;
      Cout      <= 1'b0;
      out_valid <= 1'b0;
      in_ready  <= 1'b0;
`ifdef SERIAL_SLICE_ADDER_OVF_EN
      ovf       <= 1'b0;
`endif
    end else begin
      // in_ready tracks "next state is IDLE", so it drops on accept and rises on hand-off.
      in_ready <= (state_next == IDLE);
      case (state)
        IDLE: begin
          if (accept) begin
            a_q   <= A;
            b_q   <= sub ? ~B : B;
            carry <= sub | Cin;
            cnt   <= '0;
          end
        end
        RUN: begin
          acc   <= acc_next;
          carry <= c_sl;
          cnt   <= last ? '0 : cnt + 1'b1;
          if (last) begin
            S         <= acc_next;
            Cout      <= c_sl;
            out_valid <= 1'b1;
`ifdef SERIAL_SLICE_ADDER_OVF_EN
            ovf <= (a_q[WIDTH-1] == b_q[WIDTH-1]) && (acc_next[WIDTH-1] != a_q[WIDTH-1]);
`endif
          end
        end
        DONE: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_slice_adder.sv
// Bench for serial_slice_adder: vector table, random ops, backpressure and mid-op reset.
// Build with SERIAL_SLICE_ADDER_OVF_EN defined to also check the ovf output.
module tb_serial_slice_adder;

  localparam int W      = 64;
  localparam int SL     = 16;
  localparam int NSLICE = W / SL;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready;
  logic [W-1:0] A, B, S;
  logic         Cin, sub;
  logic         out_valid, out_ready;
  logic         Cout, busy;
`ifdef SERIAL_SLICE_ADDER_OVF_EN
  logic         ovf;
`endif

  serial_slice_adder #(.WIDTH(W), .SLICE(SL)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .A(A),
    .B(B),
    .Cin(Cin),
    .sub(sub),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .S(S),
    .Cout(Cout),
    .busy(busy)
`ifdef SERIAL_SLICE_ADDER_OVF_EN
    ,
    .ovf(ovf)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic [W-1:0] s;
    logic         cout;
  } rec_t;

  localparam int NVEC = 11;
  rec_t tbl[NVEC];

  // Scoreboard entries are {ovf, cout, s}.
  logic [W+1:0] exp_q[$];
  logic [W+1:0] last_exp;
  int checks = 0;
  int errors = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [W+1:0] act, input logic [W+1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic c, input logic s);
    logic [W-1:0] bp;
    logic [W:0]   r;
    logic         o;
    bp = s ? ~b : b;
    r  = {1'b0, a} + {1'b0, bp} + {{W{1'b0}}, (s | c)};
    o  = (a[W-1] == bp[W-1]) && (r[W-1] != a[W-1]);
    return {o, r};
  endfunction

  task automatic check_result(input string name);
    logic [W+1:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s_sb_empty actual=result required=none", name);
    end else begin
      e = exp_q.pop_front();
      last_exp = e;
      check({name, "_S"}, {2'b00, S}, {2'b00, e[W-1:0]});
      check({name, "_Cout"}, {{(W+1){1'b0}}, Cout}, {{(W+1){1'b0}}, e[W]});
`ifdef SERIAL_SLICE_ADDER_OVF_EN
      check({name, "_ovf"}, {{(W+1){1'b0}}, ovf}, {{(W+1){1'b0}}, e[W+1]});
`endif
    end
  endtask

  // Waits for in_ready, hands over one operation, then checks latency and result.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                       input logic s, input logic [W+1:0] exp, input string name);
    int n;
    n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    check({name, "_in_ready"}, {{(W+1){1'b0}}, in_ready}, 1);
    A = a; B = b; Cin = c; sub = s; in_valid = 1'b1;
    exp_q.push_back(exp);
    tick();
    in_valid = 1'b0;
    A = ~a; B = ~b;
    check({name, "_busy"}, {{(W+1){1'b0}}, busy}, 1);
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    check({name, "_latency"}, (W+2)'(n), (W+2)'(NSLICE));
    check_result(name);
  endtask

  initial begin
    logic [W+1:0] m;
    logic [W-1:0] ra, rb;
    logic         rc, rs;

    tbl[0]  = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h0, 1'b1};
    tbl[1]  = '{64'h9999_9999_9999_9999, 64'h9999_9999_9999_9999, 1'b1, 1'b0, 64'h3333_3333_3333_3333, 1'b1};
    tbl[2]  = '{64'h8, 64'h7, 1'b0, 1'b1, 64'h1, 1'b1};
    tbl[3]  = '{64'h3, 64'h8, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFB, 1'b0};
    tbl[4]  = '{64'h8, 64'h7, 1'b1, 1'b1, 64'h1, 1'b1};
    tbl[5]  = '{64'h3, 64'h8, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFB, 1'b0};
    tbl[6]  = '{64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 1'b0};
    tbl[7]  = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 64'h0, 1'b1};
    tbl[8]  = '{64'h0, 64'h0, 1'b1, 1'b0, 64'h1, 1'b0};
    tbl[9]  = '{64'h0000_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h0001_0000_0000_0000, 1'b0};
    tbl[10] = '{64'h5, 64'h5, 1'b0, 1'b1, 64'h0, 1'b1};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    A = '0; B = '0; Cin = 1'b0; sub = 1'b0;
    tick();
    tick();
    check("rst_in_ready", {{(W+1){1'b0}}, in_ready}, 0);
    check("rst_out_valid", {{(W+1){1'b0}}, out_valid}, 0);
    check("rst_S", {2'b00, S}, 0);
    check("rst_Cout", {{(W+1){1'b0}}, Cout}, 0);
    check("rst_busy", {{(W+1){1'b0}}, busy}, 0);
    rst_n = 1'b1;
    check("rel_in_ready_low", {{(W+1){1'b0}}, in_ready}, 0);
    tick();
    check("rel_in_ready_high", {{(W+1){1'b0}}, in_ready}, 1);

    for (int i = 0; i < NVEC; i++) begin
      m = model(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sub);
      do_op(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sub,
            {m[W+1], tbl[i].cout, tbl[i].s}, $sformatf("vec%0d", i));
    end

    for (int i = 0; i < 8; i++) begin
      ra = {$urandom(), $urandom()};
      rb = {$urandom(), $urandom()};
      rc = 1'($urandom_range(0, 1));
      rs = 1'($urandom_range(0, 1));
      do_op(ra, rb, rc, rs, model(ra, rb, rc, rs), $sformatf("rnd%0d", i));
    end

    // Backpressure: result must hold and new operands must be refused.
    tick();
    out_ready = 1'b0;
    do_op(64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111, 1'b0, 1'b0,
          {2'b00, 64'h2345_6789_ABCD_F001}, "bp");
    for (int i = 0; i < 5; i++) begin
      in_valid = (i % 2) == 0;
      A = 64'hAAAA; B = 64'h5555;
      tick();
      check("bp_hold_S", {2'b00, S}, {2'b00, last_exp[W-1:0]});
      check("bp_hold_Cout", {{(W+1){1'b0}}, Cout}, {{(W+1){1'b0}}, last_exp[W]});
      check("bp_hold_valid", {{(W+1){1'b0}}, out_valid}, 1);
      check("bp_in_ready", {{(W+1){1'b0}}, in_ready}, 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    check("bp_release_valid", {{(W+1){1'b0}}, out_valid}, 0);
    check("bp_release_in_ready", {{(W+1){1'b0}}, in_ready}, 1);
    do_op(64'hDEAD, 64'hBEEF, 1'b0, 1'b0, {2'b00, 64'h0000_0000_0001_9D9C}, "dead_beef");

    // Reset two cycles into RUN: the in-flight op must vanish.
    tick();
    while (!in_ready) tick();
    A = 64'h1; B = 64'h1; Cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", {{(W+1){1'b0}}, out_valid}, 0);
    check("mid_rst_in_ready", {{(W+1){1'b0}}, in_ready}, 0);
    check("mid_rst_busy", {{(W+1){1'b0}}, busy}, 0);
    check("mid_rst_S", {2'b00, S}, 0);
    check("mid_rst_Cout", {{(W+1){1'b0}}, Cout}, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("mid_rst_hold_valid", {{(W+1){1'b0}}, out_valid}, 0);
    end
    rst_n = 1'b1;
    check("mid_rel_in_ready_low", {{(W+1){1'b0}}, in_ready}, 0);
    tick();
    check("mid_rel_in_ready_high", {{(W+1){1'b0}}, in_ready}, 1);
    for (int i = 0; i < 6; i++) begin
      check("mid_rel_no_output", {{(W+1){1'b0}}, out_valid}, 0);
      if (i < 5) tick();
    end
    do_op(64'h2, 64'h3, 1'b0, 1'b0, {2'b00, 64'h5}, "post_rst");

    tick();
    check("sb_drained", (W+2)'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
